// File: rtl/bf16_pair_feeder.sv
// bf16_pair_feeder: buffers bfloat16 operand pairs, issues them one at a
// time to the add core, and presents truncated bfloat16 results downstream.
//
// Ports:
//   clock, nreset          rising-edge clock, async active-low reset
//   in_valid/in_ready      operand pair push handshake (in_a, in_b)
//   core_a/core_b          registered operands {bf16, 16'h0} to the core
//   core_start             one-cycle issue pulse
//   core_ready/core_sum    core result strobe and single-precision sum
//   out_valid/out_ready    result handshake (out_sum, out_err, out_seq)
module bf16_pair_feeder #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  output logic        core_start,
  input  logic        core_ready,
  input  logic [31:0] core_sum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        out_err,
  output logic [7:0]  out_seq
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN
  } state_t;

  state_t state;
  state_t state_n;

  logic [15:0]   a_mem [DEPTH];
  logic [15:0]   b_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    timer;

  logic push;
  logic pop;
  logic load;
  logic fire_ok;
  logic fire_to;
  logic drain_hs;

  // Low half of the core result is dropped by truncation.
  logic unused_sum;
  assign unused_sum = ^core_sum[15:0];

  // Registered count only: a pop this cycle does not reopen in_ready.
  assign in_ready = count != (AW+1)'(DEPTH);
  assign push     = in_valid & in_ready;
  assign pop      = state == ISSUE;
  assign load     = (state == IDLE) && (count != '0);

  assign core_start = state == ISSUE;

  // A response in the watchdog's final cycle takes precedence.
  assign fire_ok  = (state == WAIT) && core_ready;
  assign fire_to  = (state == WAIT) && !core_ready &&
                    (timer == 8'(TIMEOUT - 1));
  assign drain_hs = (state == DRAIN) && out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (push) begin
      a_mem[wr_ptr] <= in_a;
      b_mem[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (count != '0) state_n = ISSUE;
      ISSUE:   state_n = WAIT;
      WAIT:    if (fire_ok || fire_to) state_n = DRAIN;
      DRAIN:   if (drain_hs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      core_a    <= '0;
      core_b    <= '0;
      timer     <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_err   <= 1'b0;
      out_seq   <= '0;
    end else begin
      if (load) begin
        core_a <= {a_mem[rd_ptr], 16'h0000};
        core_b <= {b_mem[rd_ptr], 16'h0000};
      end
      if (state == ISSUE) begin
        timer <= '0;
      end else if ((state == WAIT) && !fire_ok && !fire_to) begin
        timer <= timer + 8'd1;
      end
      unique case (1'b1)
        fire_ok: begin
          out_valid <= 1'b1;
          out_sum   <= core_sum[31:16];
          out_err   <= 1'b0;
        end
        fire_to: begin
          out_valid <= 1'b1;
          out_sum   <= 16'hFFFF;
          out_err   <= 1'b1;
        end
        drain_hs: begin
          out_valid <= 1'b0;
          out_seq   <= out_seq + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bf16_pair_feeder.sv
// Self-checking bench for bf16_pair_feeder: transaction-level model with
// queues plus directed literal checks and a randomized traffic phase.
module tb_bf16_pair_feeder;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic        clock;
  logic        nreset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic        core_start;
  logic        core_ready;
  logic [31:0] core_sum;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_err;
  logic [7:0]  out_seq;

  bf16_pair_feeder #(
    .DEPTH(DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock),
    .nreset(nreset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .core_a(core_a),
    .core_b(core_b),
    .core_start(core_start),
    .core_ready(core_ready),
    .core_sum(core_sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_err(out_err),
    .out_seq(out_seq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_note(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Transaction model
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  bit          busy;
  bit          pend;
  int          wc;
  logic [15:0] res_sum;
  bit          res_err;
  int          mseq;
  bit          prev_idle;
  logic [15:0] cur_a;
  logic [15:0] cur_b;
  bit          exp_start;
  bit          m_ready;
  bit          hs_in;
  bit          start_ev;

  always @(negedge clock) begin
    if (!nreset) begin
      qa.delete();
      qb.delete();
      busy = 0; pend = 0; wc = 0; mseq = 0;
      prev_idle = 0; hs_in = 0; start_ev = 0;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_core_start", 32'(core_start), 32'd0);
      chk("rst_core_a", core_a, 32'd0);
      chk("rst_core_b", core_b, 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_sum", 32'(out_sum), 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      chk("rst_out_seq", 32'(out_seq), 32'd0);
    end else begin
      m_ready   = qa.size() != DEPTH;
      exp_start = !busy && qa.size() != 0 && prev_idle;
      chk("in_ready", 32'(in_ready), 32'(m_ready));
      chk("core_start", 32'(core_start), 32'(exp_start));
      if (exp_start) begin
        chk("issue_core_a", core_a, {qa[0], 16'h0000});
        chk("issue_core_b", core_b, {qb[0], 16'h0000});
      end
      if (busy && !pend) begin
        chk("wait_core_a", core_a, {cur_a, 16'h0000});
        chk("wait_core_b", core_b, {cur_b, 16'h0000});
      end
      if (pend) begin
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("out_sum", 32'(out_sum), 32'(res_sum));
        chk("out_err", 32'(out_err), 32'(res_err));
        chk("out_seq", 32'(out_seq), 32'(mseq));
      end else begin
        chk("out_valid_idle", 32'(out_valid), 32'd0);
      end
      prev_idle = !busy && qa.size() != 0 && !exp_start;
      hs_in     = in_valid && m_ready;
      start_ev  = exp_start;
      if (exp_start) begin
        cur_a = qa.pop_front();
        cur_b = qb.pop_front();
        busy  = 1;
        wc    = 0;
      end else if (busy && !pend) begin
        if (core_ready) begin
          pend = 1; res_sum = core_sum[31:16]; res_err = 0;
        end else if (wc + 1 == TIMEOUT) begin
          pend = 1; res_sum = 16'hFFFF; res_err = 1;
        end else begin
          wc++;
        end
      end else if (pend && out_ready) begin
        pend = 0;
        busy = 0;
        mseq = (mseq + 1) % 256;
      end
      if (hs_in) begin
        qa.push_back(in_a);
        qb.push_back(in_b);
      end
    end
  end

  // Core responder: lat_mode < 0 random, 0 never, N answers in WAIT cycle N.
  int          lat_mode;
  logic [31:0] force_sum;
  int          stale_req;
  int          stale_done;
  int          cd;
  logic [31:0] rsum;

  always @(posedge clock) begin
    #1;
    core_ready = 1'b0;
    core_sum   = $urandom;
    if (!nreset) begin
      cd = 0;
    end else if (start_ev) begin
      if (lat_mode >= 0) begin
        cd   = lat_mode;
        rsum = force_sum;
      end else begin
        cd   = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
        rsum = $urandom;
      end
    end
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        core_ready = 1'b1;
        core_sum   = rsum;
      end
    end
    if (stale_req != stale_done) begin
      stale_done++;
      core_ready = 1'b1;
      core_sum   = 32'hDEADBEEF;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    fail_note("push_timeout");
  endtask

  task automatic wait_valid(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      if (out_valid) return;
    end
    fail_note("wait_valid_timeout");
  endtask

  task automatic wait_start(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      if (core_start) return;
    end
    fail_note("wait_start_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1, "global watchdog");
  end

  initial begin
    nreset     = 1'b1;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    out_ready  = 1'b1;
    lat_mode   = -1;
    force_sum  = '0;
    stale_req  = 0;
    stale_done = 0;
    cd         = 0;
    #1 nreset  = 1'b0;
    cycles(3);
    nreset = 1'b1;
    cycles(2);

    // Basic add
    lat_mode  = 3;
    force_sum = 32'h40400000;
    push_pair(16'h3F80, 16'h4000);
    wait_start(10);
    chk("basic_core_a", core_a, 32'h3F800000);
    chk("basic_core_b", core_b, 32'h40000000);
    @(negedge clock);
    chk("basic_start_width", 32'(core_start), 32'd0);
    wait_valid(20);
    chk("basic_sum", 32'(out_sum), 32'h4040);
    chk("basic_err", 32'(out_err), 32'd0);
    chk("basic_seq", 32'(out_seq), 32'd0);
    cycles(4);

    // Timeout, then a stale pulse while the result is held
    out_ready = 1'b0;
    lat_mode  = 0;
    push_pair(16'h1234, 16'h5678);
    wait_valid(40);
    chk("to_sum", 32'(out_sum), 32'hFFFF);
    chk("to_err", 32'(out_err), 32'd1);
    cycles(5);
    stale_req++;
    cycles(3);
    @(negedge clock);
    chk("stale_sum", 32'(out_sum), 32'hFFFF);
    chk("stale_err", 32'(out_err), 32'd1);
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    cycles(2);
    lat_mode  = 2;
    force_sum = 32'h3F80ABCD;
    push_pair(16'h3F00, 16'h3F00);
    wait_valid(20);
    chk("after_to_sum", 32'(out_sum), 32'h3F80);
    chk("after_to_err", 32'(out_err), 32'd0);
    cycles(4);

    // Full FIFO
    out_ready = 1'b0;
    lat_mode  = 12;
    force_sum = 32'h41000000;
    for (int i = 0; i < 5; i++) push_pair(16'(16'h1000 + i), 16'(16'h2000 + i));
    in_valid = 1'b1;
    in_a = 16'h1005;
    in_b = 16'h2005;
    cycles(3);
    @(negedge clock);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    push_pair(16'h1005, 16'h2005);
    cycles(150);

    // Coincident response in the last WAIT cycle
    lat_mode  = TIMEOUT;
    force_sum = 32'hC0A00000;
    push_pair(16'hC000, 16'hBF80);
    wait_valid(40);
    chk("coinc_sum", 32'(out_sum), 32'hC0A0);
    chk("coinc_err", 32'(out_err), 32'd0);
    cycles(4);

    // Backpressure
    out_ready = 1'b0;
    lat_mode  = 4;
    force_sum = 32'h41100000;
    for (int i = 0; i < 3; i++) push_pair(16'(16'h4000 + i), 16'h3F80);
    wait_valid(40);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(out_sum), 32'h4110);
      chk("bp_no_start", 32'(core_start), 32'd0);
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    cycles(60);

    // Reset during WAIT
    lat_mode = 0;
    for (int i = 0; i < 3; i++) push_pair(16'(16'h5000 + i), 16'h0001);
    cycles(4);
    #3 nreset = 1'b0;
    @(negedge clock);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_start", 32'(core_start), 32'd0);
    chk("mid_rst_seq", 32'(out_seq), 32'd0);
    @(posedge clock);
    #1;
    nreset = 1'b1;
    stale_req++;
    cycles(4);
    lat_mode  = 2;
    force_sum = 32'h40000000;
    push_pair(16'h3F80, 16'h3F80);
    wait_valid(20);
    chk("post_rst_seq", 32'(out_seq), 32'd0);
    chk("post_rst_sum", 32'(out_sum), 32'h4000);
    chk("post_rst_err", 32'(out_err), 32'd0);
    cycles(4);

    // Random traffic
    lat_mode = -1;
    for (int c = 0; c < 3000; c++) begin
      if (!in_valid || hs_in) begin
        in_valid = ($urandom % 3) != 0;
        in_a = 16'($urandom);
        in_b = 16'($urandom);
      end
      out_ready = ($urandom % 4) != 0;
      cycles(1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycles(200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
